// File: rtl/vga_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter_if
// Bundles the two draw-client req/ack channels and the framebuffer RAM bus
// that the arbiter drives.
//   c0_*/c1_*   : client request (req, we, x, y, wdata), accept pulse (ack),
//                 read return (rdata, rvalid)
//   mem_*       : registered RAM address/write controls, RAM read data
// Modports:
//   slave  - the arbiter side (takes client requests, drives the RAM)
//   master - the client/RAM side (raises requests, returns RAM data)
// ---------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 3
);
   logic              c0_req;
   logic              c0_we;
   logic [7:0]        c0_x;
   logic [6:0]        c0_y;
   logic [DATA_W-1:0] c0_wdata;
   logic              c0_ack;
   logic [DATA_W-1:0] c0_rdata;
   logic              c0_rvalid;

   logic              c1_req;
   logic              c1_we;
   logic [7:0]        c1_x;
   logic [6:0]        c1_y;
   logic [DATA_W-1:0] c1_wdata;
   logic              c1_ack;
   logic [DATA_W-1:0] c1_rdata;
   logic              c1_rvalid;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  c0_req, c0_we, c0_x, c0_y, c0_wdata,
      output c0_ack, c0_rdata, c0_rvalid,
      input  c1_req, c1_we, c1_x, c1_y, c1_wdata,
      output c1_ack, c1_rdata, c1_rvalid,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output c0_req, c0_we, c0_x, c0_y, c0_wdata,
      input  c0_ack, c0_rdata, c0_rvalid,
      output c1_req, c1_we, c1_x, c1_y, c1_wdata,
      input  c1_ack, c1_rdata, c1_rvalid,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between the VGA scan-out
// and two draw clients. The scan-out owns every fourth visible cycle
// (pix_x[1:0] == 0); all other cycles go to the clients in round-robin order.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   display        : scanner is in the visible region
//   pix_x, pix_y   : visible-region coordinates (640x480, scaled down by 4)
//   pix_color      : pixel word for the scan-out, two cycles after its slot
//   bus (slave)    : client req/ack/read channels and the RAM bus
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int unsigned FB_W   = 160,
   parameter int unsigned FB_H   = 120,
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              display,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   output logic [DATA_W-1:0] pix_color,
   vga_fb_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      OWN_DISP = 2'd0,
      OWN_C0   = 2'd1,
      OWN_C1   = 2'd2
   } owner_t;

   // One entry per RAM access that will return data worth keeping.
   typedef struct packed {
      logic   valid;
      owner_t owner;
      logic   oor;
   } tag_t;

   tag_t              tag_s1;
   tag_t              tag_s2;
   logic              rr_ptr;
   logic              display_slot;
   logic [ADDR_W-1:0] disp_addr;
   logic [ADDR_W-1:0] c0_addr;
   logic [ADDR_W-1:0] c1_addr;
   logic              c0_oor;
   logic              c1_oor;
   logic              grant_c0;
   logic              grant_c1;
   logic              sel_we;
   logic              sel_oor;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // The scan-out grabs the RAM on every fourth visible pixel; the 640x480
   // scanner coordinates map onto the 160x120 buffer by dropping two bits.
   assign display_slot = display && (pix_x[1:0] == 2'b00);
   assign disp_addr    = ADDR_W'(pix_y >> 2) * ADDR_W'(FB_W) + ADDR_W'(pix_x >> 2);

   assign c0_addr = ADDR_W'(bus.c0_y) * ADDR_W'(FB_W) + ADDR_W'(bus.c0_x);
   assign c1_addr = ADDR_W'(bus.c1_y) * ADDR_W'(FB_W) + ADDR_W'(bus.c1_x);
   assign c0_oor  = (32'(bus.c0_x) >= FB_W) || (32'(bus.c0_y) >= FB_H);
   assign c1_oor  = (32'(bus.c1_x) >= FB_W) || (32'(bus.c1_y) >= FB_H);

   // Client arbitration: a lone requester always wins, a tie goes to the
   // client the round-robin pointer names. Display slots block both.
   always_comb begin
      grant_c0 = 1'b0;
      grant_c1 = 1'b0;
      if (!display_slot) begin
         if (bus.c0_req && bus.c1_req) begin
            grant_c0 = !rr_ptr;
            grant_c1 = rr_ptr;
         end else begin
            grant_c0 = bus.c0_req;
            grant_c1 = bus.c1_req;
         end
      end
   end

   // Mux the winning client's request fields so the register stage below
   // only has to deal with a single candidate.
   always_comb begin
      sel_we    = grant_c1 ? bus.c1_we    : bus.c0_we;
      sel_oor   = grant_c1 ? c1_oor       : c0_oor;
      sel_addr  = grant_c1 ? c1_addr      : c0_addr;
      sel_wdata = grant_c1 ? bus.c1_wdata : bus.c0_wdata;
   end

   // Register the RAM command, the ack pulses and the two-deep read tag
   // pipeline. A tag issued with an address lines up with mem_rdata two
   // edges later, where it steers the word to the scan-out or a client.
   // Out-of-range client accesses are turned into a harmless read of
   // address 0 whose result is replaced by zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr        <= 1'b0;
         tag_s1        <= '0;
         tag_s2        <= '0;
         pix_color     <= '0;
         bus.c0_ack    <= 1'b0;
         bus.c1_ack    <= 1'b0;
         bus.c0_rvalid <= 1'b0;
         bus.c1_rvalid <= 1'b0;
         bus.c0_rdata  <= '0;
         bus.c1_rdata  <= '0;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         bus.c0_ack <= grant_c0;
         bus.c1_ack <= grant_c1;

         if (display_slot) begin
            bus.mem_addr <= disp_addr;
            bus.mem_we   <= 1'b0;
            tag_s1       <= '{valid: 1'b1, owner: OWN_DISP, oor: 1'b0};
         end else if (grant_c0 || grant_c1) begin
            bus.mem_addr  <= sel_oor ? '0 : sel_addr;
            bus.mem_we    <= sel_we && !sel_oor;
            bus.mem_wdata <= sel_wdata;
            rr_ptr        <= grant_c0;
            tag_s1        <= '{valid: !sel_we, owner: (grant_c1 ? OWN_C1 : OWN_C0), oor: sel_oor};
         end else begin
            bus.mem_we <= 1'b0;
            tag_s1     <= '0;
         end

         tag_s2 <= tag_s1;

         bus.c0_rvalid <= tag_s2.valid && (tag_s2.owner == OWN_C0);
         bus.c1_rvalid <= tag_s2.valid && (tag_s2.owner == OWN_C1);
         if (tag_s2.valid && (tag_s2.owner == OWN_C0)) begin
            bus.c0_rdata <= tag_s2.oor ? '0 : bus.mem_rdata;
         end
         if (tag_s2.valid && (tag_s2.owner == OWN_C1)) begin
            bus.c1_rdata <= tag_s2.oor ? '0 : bus.mem_rdata;
         end
         if (tag_s2.valid && (tag_s2.owner == OWN_DISP)) begin
            pix_color <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (160x120, one word per pixel) between the VGA display fetch and two draw clients (c0: scene renderer, c1: HUD/overlay).
- Display fetch has absolute priority on a fixed slot schedule derived from the scanner coordinates, so the scan-out never stalls.
- Clients share the remaining cycles with round-robin arbitration and a req/ack handshake.
- Sits between the VGA timing controller, the drawing engines and the framebuffer RAM.

Parameters:
- FB_W, 160, framebuffer width in pixels (display x >> 2)
- FB_H, 120, framebuffer height in pixels (display y >> 2)
- ADDR_W, 15, RAM address width (must satisfy FB_W*FB_H <= 2^ADDR_W)
- DATA_W, 3, pixel word width (RGB)

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- display  in  1  high while the scanner is in the visible region
- pix_x  in  10  visible-region column 0..639
- pix_y  in  10  visible-region row 0..479
- pix_color  out  DATA_W  pixel word for the scan-out
- c0_req, c1_req  in  1  client request; held high until ack
- c0_we, c1_we  in  1  1 = write, 0 = read
- c0_x, c1_x  in  8  client column
- c0_y, c1_y  in  7  client row
- c0_wdata, c1_wdata  in  DATA_W  write data
- c0_ack, c1_ack  out  1  one-cycle accept pulse
- c0_rdata, c1_rdata  out  DATA_W  read data
- c0_rvalid, c1_rvalid  out  1  one-cycle read-data-valid pulse
- mem_addr  out  ADDR_W  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after mem_addr

Behaviour:
- Address computation: addr = y*FB_W + x. Display uses x = pix_x>>2 and y = pix_y>>2.
- Display slot: every edge where display=1 and pix_x[1:0]==0. On that edge:
  - mem_addr is loaded with the display address and mem_we=0.
  - No client is granted.
- Free slot: any other edge. Arbitration among asserted requests:
  - Only one requesting client: that client is granted.
  - Both requesting: grant goes to the client indicated by a 1-bit round-robin pointer. After any grant the pointer points to the other client.
  - The pointer resets to favour c0.
- Grant edge:
  - Registers mem_addr, mem_we (= cN_we) and mem_wdata.
  - Asserts cN_ack for exactly the following cycle.
  - Clients must hold x/y/we/wdata stable while req=1 and not yet acked.
  - If req is still high in the cycle ack is visible, it is treated as a new request. Back-to-back grants are legal.
- Out-of-range client access (x >= FB_W or y >= FB_H):
  - Is acked normally, but mem_we=0 and mem_addr=0.
  - A read returns rdata=0 with rvalid.
- No-grant edge (no display slot and no request): mem_we=0, and mem_addr holds its value.
- Read pipeline: a 2-stage tag pipeline {valid, owner (display/c0/c1), oor}.
  - Grant/slot at edge k → mem_rdata sampled at edge k+2.
  - Display owner: pix_color <= mem_rdata at edge k+2, then held until the next display slot result. Latency from slot edge to pix_color is exactly 2 cycles; upstream compensates.
  - Client read: cN_rdata <= mem_rdata (or 0 if oor) and cN_rvalid=1 for one cycle, both at edge k+2.
  - Writes produce no rvalid.
- Bandwidth:
  - During the visible region, clients receive 3 of every 4 cycles.
  - Outside the visible region (display=0), clients receive every cycle and pix_color holds its last value.
- Reset (asynchronous, any time):
  - All outputs go to 0: pix_color, acks, rvalids, rdata, mem_addr, mem_we, mem_wdata.
  - The tag pipeline is flushed, so in-flight reads never raise rvalid after reset.
  - The pointer returns to c0.
- Simultaneous events: if a display slot coincides with both requests, both requests wait. The pointer is unchanged by display slots.

Test Plan:
- Display-only fetch: display=1, pix_x=0,4,8, pix_y=8, RAM preloaded with addr 320→5, 321→2 → mem_addr 320 at slot edge; pix_color=5 two cycles later; pix_color=2 after the next slot; no acks.
- Client write/read: display=0, c0 writes (x=10, y=1, wdata=6) → ack next cycle with mem_addr=170 and mem_we=1. c0 then reads the same location → c0_rvalid pulse 2 cycles after the grant edge with c0_rdata=6.
- Round-robin: display=0, c0_req and c1_req held high for 4 grants → ack order c0, c1, c0, c1; exactly one ack per cycle.
- Slot blocking: display=1 while both clients request → no ack on any edge where pix_x[1:0]==0; 3 acks per 4-cycle group, alternating clients.
- Out-of-range: c1 writes x=200 → c1_ack pulses with mem_we=0. c1 reads y=125 → c1_rvalid with c1_rdata=0.
- Reset mid-read: assert reset one cycle after a c0 read grant → all outputs 0 immediately; no c0_rvalid after release; the first grant after reset with both requests goes to c0.
